// File: rtl/fft16_pkg.sv
// fft16_pkg: shared definitions for the 16-point radix-2 DIF FFT blocks.
//   FFT_N / FFT_LOG2N / FFT_BF_PER_STAGE : transform geometry
//   TW_W      : twiddle ROM index width (ROM holds W16^0..W16^7)
//   state_t   : address-generator FSM states (UNLOAD only with FFT_AGEN_UNLOAD_EN)
//   bf_beat_t : one butterfly's operand addresses and twiddle index
//   bitrev4   : 4-bit bit reversal for natural-order readout
package fft16_pkg;

  localparam int FFT_N            = 16;
  localparam int FFT_LOG2N        = 4;
  localparam int FFT_BF_PER_STAGE = 8;
  localparam int TW_W             = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
`ifdef FFT_AGEN_UNLOAD_EN
    ST_UNLOAD,
`endif
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]      a;
    logic [3:0]      b;
    logic [TW_W-1:0] tw;
  } bf_beat_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/fft16_agen.sv
// fft16_agen: address / twiddle-index sequencer for the 16-point radix-2
// DIF FFT. Issues 4 stages x 8 butterflies, with a BF_LATENCY-cycle drain
// gap after every stage so the butterfly pipeline can write back in place.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           begin a transform (sampled only in IDLE)
//   ready           downstream accepts the current beat
//   valid           addr_a/addr_b/tw_addr/stage carry a beat
//   addr_a, addr_b  upper / lower operand sample-memory addresses
//   tw_addr         twiddle ROM index k (W16^k)
//   stage           current stage 0..3
//   busy            transform in progress
//   done            one-cycle completion pulse
//   unload          beat is a bit-reversed readout beat (only when
//                   FFT_AGEN_UNLOAD_EN is defined)
//
// Build option: define FFT_AGEN_UNLOAD_EN to append a 16-beat UNLOAD phase
// after the last drain that walks addr_a through bitrev4(0..15).
module fft16_agen
  import fft16_pkg::*;
#(
  parameter int BF_LATENCY = 4
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ready,
  output logic            valid,
  output logic [3:0]      addr_a,
  output logic [3:0]      addr_b,
  output logic [TW_W-1:0] tw_addr,
  output logic [1:0]      stage,
  output logic            busy,
  output logic            done
`ifdef FFT_AGEN_UNLOAD_EN
  ,
  output logic            unload
`endif
);

  localparam int              IDX_W      = $clog2(FFT_N);
  localparam logic [IDX_W-1:0] LAST_BF    = IDX_W'(FFT_BF_PER_STAGE - 1);
  localparam logic [1:0]       LAST_STAGE = 2'(FFT_LOG2N - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(BF_LATENCY - 1);
`ifdef FFT_AGEN_UNLOAD_EN
  localparam logic [IDX_W-1:0] LAST_UNL   = IDX_W'(FFT_N - 1);
`endif

  // Butterfly b of stage s: groups of 2*span samples, j walks within a group,
  // and the twiddle exponent scales by 2^s (taken mod 8).
  function automatic bf_beat_t bf_beat(input logic [1:0] s_i, input logic [2:0] b_i);
    logic [3:0] span;
    logic [3:0] g;
    logic [3:0] j;
    logic [3:0] a;
    bf_beat_t   r;
    span = 4'd8 >> s_i;
    g    = {1'b0, b_i} >> (2'd3 - s_i);
    j    = {1'b0, b_i} & (span - 4'd1);
    a    = ((g * span) << 1) + j;
    r.a  = a;
    r.b  = a + span;
    r.tw = TW_W'(j << s_i);
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [1:0]       s, s_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;   // butterfly index in ISSUE, beat index in UNLOAD
  logic [3:0]       cnt, cnt_nxt;   // drain cycle counter
  bf_beat_t         beat_nxt;

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ISSUE;
          s_nxt     = 2'd0;
          idx_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        if (valid && ready) begin
          if (idx == LAST_BF) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = 4'd0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          if (s != LAST_STAGE) begin
            state_nxt = ST_ISSUE;
            s_nxt     = s + 2'd1;
            idx_nxt   = '0;
          end else begin
`ifdef FFT_AGEN_UNLOAD_EN
            state_nxt = ST_UNLOAD;
            idx_nxt   = '0;
`else
            state_nxt = ST_DONE;
`endif
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`ifdef FFT_AGEN_UNLOAD_EN
      ST_UNLOAD: begin
        if (valid && ready) begin
          if (idx == LAST_UNL) state_nxt = ST_DONE;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    beat_nxt = bf_beat(s_nxt, idx_nxt[2:0]);
  end

  // Every output is registered from the next-state view, so the first beat
  // appears the cycle after start and done coincides with busy falling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s       <= 2'd0;
      idx     <= '0;
      cnt     <= 4'd0;
      valid   <= 1'b0;
      addr_a  <= 4'd0;
      addr_b  <= 4'd0;
      tw_addr <= '0;
      stage   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef FFT_AGEN_UNLOAD_EN
      unload  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      done  <= (state_nxt == ST_DONE);
      busy  <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
`ifdef FFT_AGEN_UNLOAD_EN
      valid <= (state_nxt == ST_ISSUE) || (state_nxt == ST_UNLOAD);
`else
      valid <= (state_nxt == ST_ISSUE);
`endif
      // Beat fields only move when a beat is (still) presented; while
      // ready=0 the next-state indices are unchanged, so they hold.
      if (state_nxt == ST_ISSUE) begin
        addr_a  <= beat_nxt.a;
        addr_b  <= beat_nxt.b;
        tw_addr <= beat_nxt.tw;
        stage   <= s_nxt;
`ifdef FFT_AGEN_UNLOAD_EN
        unload  <= 1'b0;
`endif
      end
`ifdef FFT_AGEN_UNLOAD_EN
      else if (state_nxt == ST_UNLOAD) begin
        addr_a  <= bitrev4(idx_nxt);
        addr_b  <= 4'd0;
        tw_addr <= '0;
        stage   <= LAST_STAGE;
        unload  <= 1'b1;
      end else begin
        unload  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft16_agen.sv
module tb_fft16_agen;

  localparam int L   = 4;
  localparam int STG = 8 + L;
`ifdef FFT_AGEN_UNLOAD_EN
  localparam int UNL = 16;
`else
  localparam int UNL = 0;
`endif
  localparam int DONE_CYC = 1 + 4 * STG + UNL;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [1:0] st;
    logic       unl;
  } exp_beat_t;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic       valid, busy, done;
  logic [3:0] addr_a, addr_b;
  logic [2:0] tw_addr;
  logic [1:0] stage;
`ifdef FFT_AGEN_UNLOAD_EN
  logic       unload;
`endif

  int        n_checks = 0;
  int        n_fail   = 0;
  int        done_cnt = 0;
  exp_beat_t sb[$];
  exp_beat_t mon_e;

  fft16_agen #(.BF_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .valid(valid), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
    .stage(stage), .busy(busy), .done(done)
`ifdef FFT_AGEN_UNLOAD_EN
    , .unload(unload)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference DIF ordering: for each stage, walk groups then offsets.
  task automatic push_run();
    int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    exp_beat_t e;
    for (int st = 0; st < 4; st++) begin
      int half = 8 >> st;
      for (int base = 0; base < 16; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          e.a   = 4'(base + j);
          e.b   = 4'(base + j + half);
          e.tw  = 3'((j * (1 << st)) % 8);
          e.st  = 2'(st);
          e.unl = 1'b0;
          sb.push_back(e);
        end
      end
    end
    if (UNL != 0) begin
      for (int n = 0; n < 16; n++) begin
        e.a = 4'(br[n]); e.b = 4'd0; e.tw = 3'd0; e.st = 2'd3; e.unl = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  function automatic bit exp_valid_at(input int c);
    for (int st = 0; st < 4; st++)
      if (c >= 1 + st * STG && c <= 8 + st * STG) return 1'b1;
    if (UNL != 0 && c >= 1 + 4 * STG && c < DONE_CYC) return 1'b1;
    return 1'b0;
  endfunction

  // Start is held across exactly one rising edge; afterwards we are in cycle 1.
  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int target);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    check("done_seen", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  32'(valid),   32'd0);
    check({tag, "_busy"},   32'(busy),    32'd0);
    check({tag, "_done"},   32'(done),    32'd0);
    check({tag, "_addr_a"}, 32'(addr_a),  32'd0);
    check({tag, "_addr_b"}, 32'(addr_b),  32'd0);
    check({tag, "_tw"},     32'(tw_addr), 32'd0);
    check({tag, "_stage"},  32'(stage),   32'd0);
`ifdef FFT_AGEN_UNLOAD_EN
    check({tag, "_unload"}, 32'(unload),  32'd0);
`endif
  endtask

  // Scoreboard: every presented beat must match the head; pop on acceptance.
  always @(negedge clk) begin
    if (!rst && valid) begin
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb[0];
        check("addr_a",  32'(addr_a),  32'(mon_e.a));
        check("addr_b",  32'(addr_b),  32'(mon_e.b));
        check("tw_addr", 32'(tw_addr), 32'(mon_e.tw));
        check("stage",   32'(stage),   32'(mon_e.st));
`ifdef FFT_AGEN_UNLOAD_EN
        check("unload",  32'(unload),  32'(mon_e.unl));
`endif
        if (ready) void'(sb.pop_front());
      end
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    int d0;
    bit hit;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Full run, ready=1: cycle-accurate valid/busy/done; start in DONE ignored.
    ready = 1'b1;
    d0 = done_cnt;
    start_run();
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      @(negedge clk);
      check($sformatf("valid@%0d", c), 32'(valid), 32'(exp_valid_at(c)));
      check($sformatf("done@%0d", c),  32'(done),  32'(c == DONE_CYC));
      check($sformatf("busy@%0d", c),  32'(busy),  32'(c < DONE_CYC));
      if (c == DONE_CYC)     start = 1'b1;
      if (c == DONE_CYC + 1) start = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("start_in_done_valid", 32'(valid), 32'd0);
    check("start_in_done_busy",  32'(busy),  32'd0);
    check("run1_sb_empty", 32'(sb.size()), 32'd0);
    check("run1_done_cnt", 32'(done_cnt),  32'(d0 + 1));

    // Random backpressure.
    d0 = done_cnt;
    start_run();
    for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    check("bp_done_cnt", 32'(done_cnt),  32'(d0 + 1));
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Interruption: start during stage 2 ignored, then async reset mid-cycle.
    d0 = done_cnt;
    start_run();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid && stage == 2'd2) begin hit = 1'b1; break; end
    end
    check("reach_stage2", 32'(hit), 32'd1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1 check_zero("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("rst_no_done",  32'(done_cnt), 32'(d0));
    check("rst_idle_busy", 32'(busy),    32'd0);
    check("rst_idle_valid", 32'(valid),  32'd0);

    // Clean run after reset.
    start_run();
    wait_done(400, d0 + 1);
    repeat (2) @(negedge clk);
    check("rerun_sb_empty", 32'(sb.size()), 32'd0);
    check("rerun_done_cnt", 32'(done_cnt),  32'(d0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
